// File: rtl/afifo_wr_framer_pkg.sv
// Shared definitions for the async-FIFO write-side framer: FSM state
// encoding and the width of the completed-packet counter.
package afifo_wr_framer_pkg;

    localparam int PKT_CNT_W = 16;

    // IDLE: no packet open, BODY: packet open, TAIL: checksum word pending
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/afifo_wr_framer.sv
// Write-side packet framer for an async FIFO. Payload beats pass through a
// one-deep output register (latency 1) and each packet is closed by an
// XOR checksum word. pkt_cnt counts checksum words actually written.
module afifo_wr_framer
    import afifo_wr_framer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 wclk,
    input  logic                 wrstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic                 wfull,
    output logic                 winc,
    output logic [WIDTH-1:0]     wdata,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);

    fsm_state_e           state_q,   state_d;
    logic [WIDTH-1:0]     csum_q,    csum_d;
    logic                 winc_q,    winc_d;
    logic [WIDTH-1:0]     wdata_q,   wdata_d;
    logic                 is_csum_q, is_csum_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic out_free;
    logic accept;
    logic wr_done;

    // The output register may be reloaded when empty or draining this edge.
    assign out_free = !winc_q || !wfull;
    // Gated by wrstn so nothing is taken while the block is held in reset.
    assign in_ready = wrstn && (state_q != TAIL) && out_free;
    assign accept   = in_valid && in_ready;
    assign wr_done  = winc_q && !wfull;

    assign winc    = winc_q;
    assign wdata   = wdata_q;
    assign pkt_cnt = pkt_cnt_q;

    // Next-state logic: FSM, checksum accumulator, output register, counter.
    always_comb begin
        state_d   = state_q;
        csum_d    = csum_q;
        winc_d    = winc_q;
        wdata_d   = wdata_q;
        is_csum_d = is_csum_q;

        // Register drains this edge; a load below overrides the bubble.
        if (out_free) begin
            winc_d    = 1'b0;
            is_csum_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    csum_d    = in_data;
                    wdata_d   = in_data;
                    winc_d    = 1'b1;
                    is_csum_d = 1'b0;
                    state_d   = in_last ? TAIL : BODY;
                end
            end
            BODY: begin
                if (accept) begin
                    csum_d    = csum_q ^ in_data;
                    wdata_d   = in_data;
                    winc_d    = 1'b1;
                    is_csum_d = 1'b0;
                    if (in_last) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    wdata_d   = csum_q;
                    winc_d    = 1'b1;
                    is_csum_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Count a packet only when its checksum word is actually written;
        // the 16-bit add wraps silently.
        pkt_cnt_d = pkt_cnt_q + {{(PKT_CNT_W-1){1'b0}}, (wr_done && is_csum_q)};
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state_q   <= IDLE;
            csum_q    <= '0;
            winc_q    <= 1'b0;
            wdata_q   <= '0;
            is_csum_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            csum_q    <= csum_d;
            winc_q    <= winc_d;
            wdata_q   <= wdata_d;
            is_csum_q <= is_csum_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_afifo_wr_framer.sv
// Scoreboard bench for afifo_wr_framer: scenarios push the FIFO words they
// expect; an independent monitor pops and compares on every real write.
module tb_afifo_wr_framer;

    logic        wclk;
    logic        wrstn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [15:0] pkt_cnt;

    int          n_checks;
    int          n_fails;
    bit          verbose;
    logic [7:0]  exp_q[$];

    afifo_wr_framer #(.WIDTH(8)) dut (
        .wclk    (wclk),
        .wrstn   (wrstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_last (in_last),
        .wfull   (wfull),
        .winc    (winc),
        .wdata   (wdata),
        .pkt_cnt (pkt_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a write happens at the next rising edge when winc=1 and wfull=0.
    always @(negedge wclk) begin
        if (wrstn === 1'b1 && winc === 1'b1 && wfull === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, wdata}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (verbose) $display("write wdata=%02h expected=%02h", wdata, e);
                check("fifo_word", {24'h0, wdata}, {24'h0, e});
            end
        end
    end

    // Apply reset, checking the reset state and the in_ready gate.
    task automatic do_reset();
        @(posedge wclk); #1;
        wrstn    = 1'b0;
        in_valid = 1'b1;
        exp_q.delete();
        @(negedge wclk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_winc",     {31'h0, winc},     32'h0);
        check("rst_wdata",    {24'h0, wdata},    32'h0);
        check("rst_pkt_cnt",  {16'h0, pkt_cnt},  32'h0);
        @(posedge wclk); #1;
        in_valid = 1'b0;
        wrstn    = 1'b1;
    endtask

    // Present one beat and hold it until the handshake edge.
    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge wclk);
            if (in_ready) begin
                @(posedge wclk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
    endtask

    // Wait for all expected words to be written and the register to empty.
    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge wclk);
            if (exp_q.size() == 0 && !winc) return;
        end
        check("drain_timeout", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        int lows;
        n_checks = 0;
        n_fails  = 0;
        verbose  = 1'b1;
        wrstn    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        wfull    = 1'b0;

        // 3-beat packet: 11, 22, 44 then checksum 77
        do_reset();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h44); exp_q.push_back(8'h77);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h44, 1'b1);
        drain();
        check("pkt_cnt_3beat", {16'h0, pkt_cnt}, 32'd1);

        // Single beat A5: two words, in_ready low for exactly one cycle
        do_reset();
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wclk);
            if (in_ready) break;
            lows++;
        end
        check("tail_ready_low_cycles", lows, 32'd1);
        drain();
        check("pkt_cnt_single", {16'h0, pkt_cnt}, 32'd1);

        // Backpressure: wfull held 4 cycles while wdata=22
        do_reset();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h44); exp_q.push_back(8'h77);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        wfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            check("hold_wdata",    {24'h0, wdata},    32'h22);
            check("hold_winc",     {31'h0, winc},     32'h1);
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge wclk); #1;
        end
        check("hold_no_write_q", exp_q.size(), 32'd3);
        wfull = 1'b0;
        send(8'h44, 1'b1);
        drain();
        check("pkt_cnt_bp", {16'h0, pkt_cnt}, 32'd1);

        // Back-to-back packets {01,02} {03}
        do_reset();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h03); exp_q.push_back(8'h03);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        drain();
        check("pkt_cnt_b2b", {16'h0, pkt_cnt}, 32'd2);

        // Reset mid-packet discards it; next packet {05} is clean
        do_reset();
        send(8'h10, 1'b0);
        wrstn = 1'b0;
        @(negedge wclk);
        check("midrst_winc", {31'h0, winc}, 32'h0);
        @(posedge wclk); #1;
        wrstn = 1'b1;
        exp_q.push_back(8'h05); exp_q.push_back(8'h05);
        send(8'h05, 1'b1);
        drain();
        check("pkt_cnt_midrst", {16'h0, pkt_cnt}, 32'd1);

        // Counter wrap: 65537 single-beat packets
        do_reset();
        verbose = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            automatic logic [7:0] d = 8'(i);
            exp_q.push_back(d); exp_q.push_back(d);
            send(d, 1'b1);
        end
        drain();
        verbose = 1'b1;
        check("pkt_cnt_wrap", {16'h0, pkt_cnt}, 32'h0001);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
